pcie_egress_req_splitter: RTL

- Sits directly upstream of the PCIe egress TLP builder. Accepts one DMA request (read or write, 64-bit address, total dword count).
- Splits the request into legal TLP-sized chunks: max payload for writes, max read request for reads, never crossing a 4 KB boundary.
- Drives the egress enable/finished command handshake once per chunk, advancing address and tag between chunks.

---
 rtl/pcie_egress_req_splitter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pcie_egress_req_splitter.sv
// Splits one DMA read/write request into PCIe-legal TLP chunks (size limit and
// 4 KB boundary) and hands each chunk to the egress builder via enable/finished.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for a request strobe; also retires zero-length requests
// CALC    | size the next chunk and load the egress command fields
// ISSUE   | o_eg_enable high, waiting for egress finished
// RELEASE | enable dropped, waiting for egress to clear finished
// NEXT    | advance address/remaining/tag, complete or loop back to CALC
module pcie_egress_req_splitter #(
    parameter logic [7:0] MRD_CMD  = 8'h20,
    parameter logic [7:0] MWR_CMD  = 8'h60,
    parameter int         NUM_TAGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_stb,
    input  logic        i_req_write,
    input  logic [63:0] i_req_address,
    input  logic [23:0] i_req_dword_total,
    input  logic [2:0]  i_max_payload_sel,
    input  logic [2:0]  i_max_read_sel,
    output logic        o_req_busy,
    output logic        o_req_done,
    output logic        o_eg_enable,
    input  logic        i_eg_finished,
    output logic [7:0]  o_eg_command,
    output logic [63:0] o_eg_address,
    output logic [9:0]  o_eg_dword_cnt,
    output logic [7:0]  o_eg_tag,
    output logic [15:0] o_chunk_count
);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ISSUE,
        RELEASE,
        NEXT
    } state_t;

    state_t      state;
    logic        req_write;
    logic [63:0] cur_addr;
    logic [23:0] remaining;
    logic [2:0]  size_sel;
    logic [12:0] chunk_len;
    logic [7:0]  tag_cnt;

    logic [12:0] max_size;
    logic [12:0] bound_room;
    logic [12:0] rem_clip;
    logic [12:0] chunk_calc;
    logic [23:0] rem_next;

    always_comb begin
        case (size_sel)
            3'd0:    max_size = 13'd32;
            3'd1:    max_size = 13'd64;
            3'd2:    max_size = 13'd128;
            3'd3:    max_size = 13'd256;
            3'd4:    max_size = 13'd512;
            default: max_size = 13'd1024;
        endcase
    end

    // Clamp before narrowing so large remaining counts cannot alias to small chunks.
    always_comb begin
        bound_room = 13'd1024 - {3'b000, cur_addr[11:2]};
        rem_clip   = (remaining > 24'd1024) ? 13'd1024 : remaining[12:0];
        chunk_calc = rem_clip;
        if (max_size < chunk_calc) chunk_calc = max_size;
        if (bound_room < chunk_calc) chunk_calc = bound_room;
    end

    assign rem_next = remaining - {11'b0, chunk_len};

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            req_write      <= 1'b0;
            cur_addr       <= 64'd0;
            remaining      <= 24'd0;
            size_sel       <= 3'd0;
            chunk_len      <= 13'd0;
            tag_cnt        <= 8'd0;
            o_req_busy     <= 1'b0;
            o_req_done     <= 1'b0;
            o_eg_enable    <= 1'b0;
            o_eg_command   <= 8'd0;
            o_eg_address   <= 64'd0;
            o_eg_dword_cnt <= 10'd0;
            o_eg_tag       <= 8'd0;
            o_chunk_count  <= 16'd0;
        end else begin
            o_req_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Busy while still in IDLE means a zero-length request was just accepted.
                    if (o_req_busy) begin
                        o_req_busy <= 1'b0;
                        o_req_done <= 1'b1;
                    end else if (i_req_stb) begin
                        req_write     <= i_req_write;
                        cur_addr      <= i_req_address & ~64'd3;
                        remaining     <= i_req_dword_total;
                        size_sel      <= i_req_write ? i_max_payload_sel : i_max_read_sel;
                        o_chunk_count <= 16'd0;
                        o_req_busy    <= 1'b1;
                        if (i_req_dword_total != 24'd0) state <= CALC;
                    end
                end
                CALC: begin
                    chunk_len      <= chunk_calc;
                    o_eg_address   <= cur_addr;
                    o_eg_command   <= req_write ? MWR_CMD : MRD_CMD;
                    o_eg_dword_cnt <= chunk_calc[9:0];
                    o_eg_tag       <= req_write ? 8'd0 : tag_cnt;
                    o_eg_enable    <= 1'b1;
                    state          <= ISSUE;
                end
                ISSUE: begin
                    if (i_eg_finished) begin
                        o_eg_enable <= 1'b0;
                        state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!i_eg_finished) state <= NEXT;
                end
                NEXT: begin
                    cur_addr      <= cur_addr + {49'b0, chunk_len, 2'b00};
                    remaining     <= rem_next;
                    o_chunk_count <= o_chunk_count + 16'd1;
                    if (!req_write) begin
                        if (tag_cnt == 8'(NUM_TAGS - 1)) tag_cnt <= 8'd0;
                        else                             tag_cnt <= tag_cnt + 8'd1;
                    end
                    if (rem_next == 24'd0) begin
                        o_req_done <= 1'b1;
                        o_req_busy <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        state <= CALC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
